// File: rtl/prio_rr_arbiter.sv
// Output-port arbiter for the router switch-allocation stage.
// Picks the highest-priority requester (one-hot priority fields), breaks ties
// round-robin, and holds the grant for a whole packet until the tail handshake.
// Optional starvation guard: define STARVATION_GUARD_EN to add per-port
// saturating wait counters that promote long-waiting ports to top priority.
module prio_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned PRIO_W     = 4,
  parameter int unsigned WAIT_LIMIT = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*PRIO_W-1:0]  prio_i,
  input  logic [NUM_REQ-1:0]         tail_i,
  input  logic                       ready_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic                       grant_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
  output logic                       xfer_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  localparam logic [PRIO_W-1:0] LowPrio = PRIO_W'(1);
  localparam logic [PRIO_W-1:0] TopPrio = PRIO_W'(1) << (PRIO_W - 1);

  // Pairwise compare encoding: left operand strictly higher.
  localparam logic [1:0] CmpLeft = 2'b01;

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } state_e;

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("prio_rr_arbiter: NUM_REQ must be in 2..8");
  end
  if (PRIO_W < 2) begin : g_bad_prio_w
    $error("prio_rr_arbiter: PRIO_W must be at least 2");
  end
  // The wait counters are 4 bits wide, so the limit must be reachable.
  if (WAIT_LIMIT < 1 || WAIT_LIMIT > 15) begin : g_bad_wait_limit
    $error("prio_rr_arbiter: WAIT_LIMIT must be in 1..15");
  end

  // A field is valid only when exactly one bit is set.
  function automatic logic is_onehot(logic [PRIO_W-1:0] v);
    return (v != '0) && ((v & (v - PRIO_W'(1))) == '0);
  endfunction

  // One-hot fields order numerically, so a plain magnitude compare suffices.
  // Returns 01 when left is higher, 10 when right is higher, 00 when equal.
  function automatic logic [1:0] prio_cmp(logic [PRIO_W-1:0] left, logic [PRIO_W-1:0] right);
    if (left > right) begin
      return 2'b01;
    end else if (left < right) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  state_e                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IdxW-1:0]        grant_idx_q, grant_idx_d;
  logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]     promoted;
  logic [PRIO_W-1:0]      eff_prio [NUM_REQ];
  logic [PRIO_W-1:0]      best_prio;
  logic                   best_valid;
  logic [NUM_REQ-1:0]     cand;
  logic [IdxW-1:0]        win_idx;
  logic                   win_found;
  logic [IdxW-1:0]        scan_idx;
  logic [IdxW-1:0]        next_ptr;
  logic                   xfer;
  logic                   release_pkt;

`ifdef STARVATION_GUARD_EN
  localparam logic [3:0] WaitLimit = 4'(WAIT_LIMIT);
  localparam logic [3:0] WaitMax   = 4'hf;

  logic [3:0] wait_cnt_q [NUM_REQ];
  logic [3:0] wait_cnt_d [NUM_REQ];

  // Ports that have waited long enough are lifted to the top priority level.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      promoted[k] = (wait_cnt_q[k] >= WaitLimit);
    end
  end

  // Count lost IDLE arbitrations; clear on grant or when idle without a request.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      wait_cnt_d[k] = wait_cnt_q[k];
      if (state_q == StIdle) begin
        if (!req_i[k] || (win_idx == IdxW'(k))) begin
          wait_cnt_d[k] = '0;
        end else if (wait_cnt_q[k] != WaitMax) begin
          wait_cnt_d[k] = wait_cnt_q[k] + 4'd1;
        end
      end
    end
  end

  // Wait counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        wait_cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        wait_cnt_q[k] <= wait_cnt_d[k];
      end
    end
  end
`else
  assign promoted = '0;
`endif

  // Decode each field to an effective one-hot level; invalid fields drop to the lowest.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (promoted[k]) begin
        eff_prio[k] = TopPrio;
      end else if (is_onehot(prio_i[k*PRIO_W +: PRIO_W])) begin
        eff_prio[k] = prio_i[k*PRIO_W +: PRIO_W];
      end else begin
        eff_prio[k] = LowPrio;
      end
    end
  end

  // Find the highest level among requesters and mark every requester at that level.
  always_comb begin
    best_prio  = '0;
    best_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_i[k]) begin
        if (!best_valid || (prio_cmp(eff_prio[k], best_prio) == CmpLeft)) begin
          best_prio  = eff_prio[k];
          best_valid = 1'b1;
        end
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      cand[k] = req_i[k] && best_valid && (eff_prio[k] == best_prio);
    end
  end

  // Round-robin pick: first candidate at or after rr_ptr, wrapping to 0.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = IdxW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!win_found && cand[scan_idx]) begin
        win_idx   = scan_idx;
        win_found = 1'b1;
      end
    end
  end

  // Transfer and end-of-packet detection for the locked port.
  always_comb begin
    xfer        = (state_q == StLocked) && req_i[grant_idx_q] && ready_i;
    release_pkt = xfer && tail_i[grant_idx_q];
    next_ptr    = (grant_idx_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx_q + IdxW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: lock on any request, unlock on the tail handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (release_pkt) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Grant and round-robin pointer next-state.
  always_comb begin
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (|req_i) begin
          grant_d     = NUM_REQ'(1) << win_idx;
          grant_idx_d = win_idx;
        end
      end
      StLocked: begin
        if (release_pkt) begin
          grant_d     = '0;
          grant_idx_d = '0;
          rr_ptr_d    = next_ptr;
        end
      end
      default: begin
        grant_d     = '0;
        grant_idx_d = '0;
      end
    endcase
  end

  // Grant and round-robin pointer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q     <= '0;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
    end else begin
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // FSM outputs.
  always_comb begin
    grant_o       = grant_q;
    grant_valid_o = (state_q == StLocked);
    grant_idx_o   = grant_idx_q;
    xfer_o        = xfer;
  end

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Self-checking bench for prio_rr_arbiter: directed scenarios plus a randomized
// run compared against a cycle-level reference model built from the arbitration rules.
module tb_prio_rr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int PRIO_W     = 4;
  localparam int WAIT_LIMIT = 2;
  localparam int IDX_W      = $clog2(NUM_REQ);

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*PRIO_W-1:0] prio;
  logic [NUM_REQ-1:0]        tail;
  logic                      ready;
  logic [NUM_REQ-1:0]        grant_o;
  logic                      grant_valid_o;
  logic [IDX_W-1:0]          grant_idx_o;
  logic                      xfer_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit m_locked;
  int m_idx;
  int m_rr;
  int m_cnt [NUM_REQ];

  prio_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .PRIO_W    (PRIO_W),
    .WAIT_LIMIT(WAIT_LIMIT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .prio_i       (prio),
    .tail_i       (tail),
    .ready_i      (ready),
    .grant_o      (grant_o),
    .grant_valid_o(grant_valid_o),
    .grant_idx_o  (grant_idx_o),
    .xfer_o       (xfer_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired (actual running, required finished)");
    $fatal(1);
  end

  task automatic set_prio(input int k, input logic [PRIO_W-1:0] v);
    prio[k*PRIO_W +: PRIO_W] = v;
  endtask

  // Numeric priority level of port k: bit position of a one-hot field, else 0.
  function automatic int prio_level(input int k);
    logic [PRIO_W-1:0] f;
    f = prio[k*PRIO_W +: PRIO_W];
`ifdef STARVATION_GUARD_EN
    if (m_cnt[k] >= WAIT_LIMIT) return PRIO_W - 1;
`endif
    if ($countones(f) != 1) return 0;
    for (int b = 0; b < PRIO_W; b++) begin
      if (f[b]) return b;
    end
    return 0;
  endfunction

  // Highest level wins; ties go to the first requester at or after m_rr.
  function automatic int model_winner();
    int best;
    int idx;
    best = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req[k] && prio_level(k) > best) best = prio_level(k);
    end
    if (best < 0) return -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (m_rr + i) % NUM_REQ;
      if (req[idx] && prio_level(idx) == best) return idx;
    end
    return -1;
  endfunction

  // Advance one clock: model update from the inputs present at the edge.
  task automatic step();
    bit nl;
    int ni;
    int nr;
    int nc [NUM_REQ];
    int w;
    nl = m_locked;
    ni = m_idx;
    nr = m_rr;
    nc = m_cnt;
    if (rst) begin
      nl = 0;
      ni = 0;
      nr = 0;
      foreach (nc[k]) nc[k] = 0;
    end else if (!m_locked) begin
      w = model_winner();
      if (w >= 0) begin
        nl = 1;
        ni = w;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!req[k] || k == w) nc[k] = 0;
        else if (nc[k] < 15) nc[k] = nc[k] + 1;
      end
    end else if (req[m_idx] && ready && tail[m_idx]) begin
      nl = 0;
      ni = 0;
      nr = (m_idx + 1) % NUM_REQ;
    end
    @(posedge clk);
    #1;
    m_locked = nl;
    m_idx    = ni;
    m_rr     = nr;
    m_cnt    = nc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req   = '0;
    prio  = '0;
    tail  = '0;
    ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    n_tests++;
    if (grant_o !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_grant: got %b, expected 0000", grant_o);
    end
    n_tests++;
    if (grant_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b, expected 0", grant_valid_o);
    end
    n_tests++;
    if (grant_idx_o !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_idx: got %0d, expected 0", grant_idx_o);
    end
    n_tests++;
    if (xfer_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_xfer: got %b, expected 0", xfer_o);
    end
  endtask

  task automatic test_basic_grant();
    req = 4'b0101;
    prio = '0;
    set_prio(0, 4'b0010);
    set_prio(2, 4'b1000);
    tail  = '0;
    ready = 1'b0;
    step();
    n_tests++;
    if (grant_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL basic_grant: got %b, expected 0100", grant_o);
    end
    n_tests++;
    if (grant_idx_o !== 2'd2) begin
      n_fail++;
      $display("FAIL basic_idx: got %0d, expected 2", grant_idx_o);
    end
    n_tests++;
    if (grant_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_valid: got %b, expected 1", grant_valid_o);
    end
  endtask

  // Continues from test_basic_grant with port 2 locked.
  task automatic test_locked_hold();
    ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      tail = (f == 2) ? 4'b0100 : 4'b0000;
      // Activity on other ports must not disturb the lock.
      req[0] = (f != 1);
      set_prio(0, 4'b1000);
      #1;
      n_tests++;
      if (xfer_o !== 1'b1) begin
        n_fail++;
        $display("FAIL locked_xfer[%0d]: got %b, expected 1", f, xfer_o);
      end
      n_tests++;
      if (grant_o !== 4'b0100) begin
        n_fail++;
        $display("FAIL locked_grant[%0d]: got %b, expected 0100", f, grant_o);
      end
      step();
    end
    n_tests++;
    if (grant_o !== 4'b0000 || grant_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL after_tail: got grant %b valid %b, expected 0000/0", grant_o, grant_valid_o);
    end
    // With equal priorities, rr_ptr=3 must select port 3.
    req  = 4'b1111;
    tail = 4'b0000;
    for (int k = 0; k < NUM_REQ; k++) set_prio(k, 4'b0010);
    step();
    n_tests++;
    if (grant_idx_o !== 2'd3) begin
      n_fail++;
      $display("FAIL rr_after_tail: got %0d, expected 3", grant_idx_o);
    end
    tail = 4'b1000;
    step();
  endtask

  task automatic test_tie_rr();
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req   = 4'b1111;
    tail  = 4'b1111;
    ready = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) set_prio(k, 4'b0100);
    for (int p = 0; p < 5; p++) begin
      step();
      n_tests++;
      if (grant_idx_o !== IDX_W'(exp_seq[p]) || grant_o !== (4'b0001 << exp_seq[p])) begin
        n_fail++;
        $display("FAIL tie_rr[%0d]: got idx %0d grant %b, expected idx %0d", p, grant_idx_o,
                 grant_o, exp_seq[p]);
      end
      n_tests++;
      if (xfer_o !== 1'b1) begin
        n_fail++;
        $display("FAIL tie_xfer[%0d]: got %b, expected 1", p, xfer_o);
      end
      step();
      n_tests++;
      if (grant_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL tie_gap[%0d]: got valid %b, expected 0", p, grant_valid_o);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req   = 4'b0010;
    prio  = '0;
    set_prio(1, 4'b0100);
    tail  = 4'b0010;
    ready = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (xfer_o !== 1'b0 || grant_o !== 4'b0010) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got xfer %b grant %b, expected 0/0010", c, xfer_o,
                 grant_o);
      end
      step();
    end
    ready = 1'b1;
    step();
    // Invalid 0110 must rank as lowest, tying with 0001.
    do_reset();
    req  = 4'b1010;
    prio = '0;
    set_prio(1, 4'b0110);
    set_prio(3, 4'b0001);
    tail  = 4'b1010;
    ready = 1'b0;
    step();
    n_tests++;
    if (grant_idx_o !== 2'd1) begin
      n_fail++;
      $display("FAIL invalid_prio_a: got %0d, expected 1", grant_idx_o);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    n_tests++;
    if (grant_idx_o !== 2'd3) begin
      n_fail++;
      $display("FAIL invalid_prio_b: got %0d, expected 3", grant_idx_o);
    end
    ready = 1'b1;
    step();
  endtask

  task automatic test_mid_reset();
    do_reset();
    req   = 4'b0100;
    prio  = '0;
    set_prio(2, 4'b0001);
    tail  = 4'b0100;
    ready = 1'b1;
    step();
    step();
    tail = 4'b0000;
    step();
    step();
    n_tests++;
    if (grant_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_reset_locked: got %b, expected 0100", grant_o);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (grant_o !== 4'b0000 || grant_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_drop: got grant %b valid %b, expected 0000/0", grant_o,
               grant_valid_o);
    end
    req = 4'b1111;
    for (int k = 0; k < NUM_REQ; k++) set_prio(k, 4'b0001);
    step();
    n_tests++;
    if (grant_idx_o !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset_rr: got %0d, expected 0", grant_idx_o);
    end
    ready = 1'b1;
    tail  = 4'b1111;
    step();
  endtask

  task automatic test_starvation();
    int first0;
    first0 = -1;
    do_reset();
    req  = 4'b0011;
    prio = '0;
    set_prio(0, 4'b0001);
    set_prio(1, 4'b1000);
    tail  = 4'b0011;
    ready = 1'b1;
    for (int a = 0; a < 4; a++) begin
      step();
      if (grant_idx_o === 2'd0 && grant_valid_o === 1'b1 && first0 < 0) first0 = a;
      step();
    end
    n_tests++;
`ifdef STARVATION_GUARD_EN
    if (first0 != 2) begin
      n_fail++;
      $display("FAIL starvation_promote: port0 first granted at arb %0d, expected 2", first0);
    end
`else
    if (first0 != -1) begin
      n_fail++;
      $display("FAIL no_guard_prio: port0 granted at arb %0d, expected never", first0);
    end
`endif
  endtask

  function automatic logic [PRIO_W-1:0] rand_field();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return PRIO_W'(1) << (r % PRIO_W);
    return PRIO_W'($urandom_range(0, (1 << PRIO_W) - 1));
  endfunction

  task automatic test_random();
    logic [NUM_REQ-1:0] exp_g;
    logic [IDX_W-1:0]   exp_i;
    logic               exp_x;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      req = NUM_REQ'($urandom);
      for (int k = 0; k < NUM_REQ; k++) set_prio(k, rand_field());
      tail  = NUM_REQ'($urandom);
      ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_g = m_locked ? (NUM_REQ'(1) << m_idx) : '0;
      exp_i = m_locked ? IDX_W'(m_idx) : '0;
      exp_x = m_locked && req[m_idx] && ready;
      n_tests++;
      if (grant_o !== exp_g || grant_valid_o !== m_locked) begin
        n_fail++;
        $display("FAIL rand_grant[%0d]: got %b/%b, expected %b/%b", c, grant_o, grant_valid_o,
                 exp_g, m_locked);
      end
      n_tests++;
      if (grant_idx_o !== exp_i) begin
        n_fail++;
        $display("FAIL rand_idx[%0d]: got %0d, expected %0d", c, grant_idx_o, exp_i);
      end
      n_tests++;
      if (xfer_o !== exp_x) begin
        n_fail++;
        $display("FAIL rand_xfer[%0d]: got %b, expected %b", c, xfer_o, exp_x);
      end
      n_tests++;
      if ($countones(grant_o) > 1) begin
        n_fail++;
        $display("FAIL rand_onehot[%0d]: got %b, expected at most one bit", c, grant_o);
      end
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    m_locked = 0;
    m_idx    = 0;
    m_rr     = 0;
    foreach (m_cnt[k]) m_cnt[k] = 0;
    rst   = 1'b1;
    req   = '0;
    prio  = '0;
    tail  = '0;
    ready = 1'b0;
    test_reset();
    test_basic_grant();
    test_locked_hold();
    test_tie_rr();
    test_backpressure();
    test_mid_reset();
    test_starvation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
